calc_display: RTL and testbench
===============================

Name: calc_display

Overview:
- Downstream display stage for the calculator core.
- Consumes the serial digit stream produced on `data`/`pos` during the PRINT phase, and assembles a frame in a shadow buffer. On frame completion it commits the frame to a live buffer.
- Time-multiplexes 8 common-anode seven-segment displays from the live buffer, with leading-zero blanking and an error pattern.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit (≥2).
- NDIG, 8, number of display digits (fixed at 8; pos is 4 bits).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- status  input  2  calc status: 00 error, 01 busy, 10 ready.
- data  input  4  BCD digit for position `pos`.
- pos  input  4  digit position (0 = least significant); value 8 marks end of frame.
- an  output  8  digit enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse when a frame is committed.
- err  output  1  high while the error pattern is shown.

Behaviour:

Reset (reset=0, asynchronous):
- Outputs: an=8'hFE, seg=7'h7F (blank), frame_done=0, err=0.
- Internal state: shadow and live buffers all 4'hF (blank), scan index=0, prescaler=0.

Capture (sampled every rising edge):
- wr = (status==01) && (pos<=7): shadow[pos] <= data. Rewriting the same pos overwrites it.
- Commit happens when status==01, pos==8, and the previous-cycle pos!=8 (edge detect, so only one commit per frame).
  - live <= shadow, with data written in the same cycle already included.
  - frame_done=1 for exactly the following cycle.
- pos 9..15 and status==10 are ignored; the buffers hold.
- Positions not rewritten in a frame keep their earlier shadow value.

Error:
- status==00 sets a sticky err flag on the next edge; only reset clears it.
- While err=1:
  - capture and commit are disabled;
  - the scan shows "Erro" on digits 3..0: E=7'h06, r=7'h2F, r=7'h2F, o=7'h23;
  - digits 7..4 are blank.

Scan state machine:
- Prescaler counts 0..SCAN_DIV-1, then wraps. On the wrap, scan index advances 0→1→…→7→0.
- an = ~(1<<index), registered; it changes one cycle after the prescaler wrap.
- seg is registered in the same cycle as an, so there is no glitch between digits.
- Every digit is lit for exactly SCAN_DIV cycles; a full refresh takes 8*SCAN_DIV cycles.

Segment decode (active-low):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Codes 10..15 display blank (7F).

Leading-zero blanking:
- Digit i (i≥1) is blank if live[j] ∈ {0, ≥10} for all j≥i.
- Digit 0 always shows, so a value of 0 displays a single "0".
- Blanking is computed from the live buffer only.

Simultaneous events:
- A commit in a cycle where the scan advances: the new digit shows the new live value.
- status==00 in the same cycle as a commit: the error takes priority and no commit occurs.

Reset mid-frame:
- Everything returns to reset values; the partial shadow contents are discarded.

Test Plan:
1. Reset released, SCAN_DIV=4, no stimulus -> an cycles FE,FD,FB,…,7F,FE with 4 cycles each; seg stays 7F throughout; frame_done stays 0.
2. status=01, pos 0..7 with data 3,2,1,0,0,0,0,0, then pos=8 -> frame_done one pulse. Digit0=30, digit1=24, digit2=79; digits 3..7 blank.
3. Frame of all zeros committed -> digit0=40 only; other digits blank.
4. Frame with 7 at pos 0, then pos held at 8 for 5 cycles -> exactly one frame_done pulse; a second frame after pos returns to 0 gives a second pulse.
5. status=00 during shadow writes -> err=1 next cycle. Digits 3..0 show 06,2F,2F,23 and 7..4 are blank. Further frames are ignored until reset.
6. Reset asserted while pos=4 mid-frame, then released and a frame 5,0,…0 committed -> only digit0 shows 12; no stale digits from the aborted frame.

Source files
------------

// File: rtl/calc_display.sv
// calc_display: display stage for the calculator core.
// Captures the serial digit stream (data/pos) into a shadow buffer while the
// core is busy. When pos reaches the end marker (8), the shadow buffer is
// committed to the live buffer. The live buffer is scanned onto 8 common-anode
// seven-segment digits, with leading-zero blanking and a sticky error pattern.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset
//   status     - calc status: 00 error, 01 busy, 10 ready
//   data       - BCD digit for position pos
//   pos        - digit position (0 = LSD); 8 marks end of frame
//   an         - digit enables, active-low, one-hot-low
//   seg        - segments {g,f,e,d,c,b,a}, active-low
//   frame_done - one-cycle pulse after a frame is committed
//   err        - high while the error pattern is shown
module calc_display #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned NDIG     = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      status,
    input  logic [3:0]      data,
    input  logic [3:0]      pos,
    output logic [NDIG-1:0] an,
    output logic [6:0]      seg,
    output logic            frame_done,
    output logic            err
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = 3;

    localparam logic [1:0] ST_ERR  = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [3:0] POS_END = 4'd8;
    localparam logic [3:0] POS_MAX = 4'd7;
    localparam logic [3:0] BLANK   = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [3:0]    shadow [NDIG];
    logic [3:0]    live   [NDIG];
    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic [3:0]    pos_q;

    logic            wr_c;
    logic            commit_c;
    logic            wrap_c;
    logic [NDIG-1:0] sig_c;
    logic [6:0]      seg_c;

    // BCD to active-low segments; codes 10..15 are blank.
    function automatic logic [6:0] dec7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // Capture/commit qualifiers; a sticky error disables both.
    always_comb begin
        wr_c     = !err && (status == ST_BUSY) && (pos <= POS_MAX);
        commit_c = !err && (status == ST_BUSY) && (pos == POS_END) && (pos_q != POS_END);
        wrap_c   = (presc == PW'(SCAN_DIV - 1));
    end

    // sig_c[i]: some digit at or above i holds a nonzero BCD value.
    always_comb begin
        logic run;
        run   = 1'b0;
        sig_c = '0;
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
            run      = run | ((live[i] != 4'd0) && (live[i] < 4'd10));
            sig_c[i] = run;
        end
    end

    // Segment pattern for the digit currently selected by idx.
    always_comb begin
        seg_c = SEG_OFF;
        if (err) begin
            case (idx)
                3'd3:    seg_c = 7'h06;
                3'd2:    seg_c = 7'h2F;
                3'd1:    seg_c = 7'h2F;
                3'd0:    seg_c = 7'h23;
                default: seg_c = SEG_OFF;
            endcase
        end else if ((idx != '0) && !sig_c[idx]) begin
            seg_c = SEG_OFF;
        end else begin
            seg_c = dec7(live[idx]);
        end
    end

    // Capture, commit, error flag and digit scan.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                shadow[i] <= BLANK;
                live[i]   <= BLANK;
            end
            presc      <= '0;
            idx        <= '0;
            pos_q      <= '0;
            an         <= ~NDIG'(1);
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            pos_q      <= pos;
            frame_done <= commit_c;
            if (status == ST_ERR) begin
                err <= 1'b1;
            end
            if (wr_c) begin
                shadow[pos[IW-1:0]] <= data;
            end
            // pos==8 never writes, so the shadow is already complete here.
            if (commit_c) begin
                for (int i = 0; i < int'(NDIG); i++) begin
                    live[i] <= shadow[i];
                end
            end
            if (wrap_c) begin
                presc <= '0;
                idx   <= idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            // an and seg are registered together from the same idx.
            an  <= ~(NDIG'(1) << idx);
            seg <= seg_c;
        end
    end

endmodule

// File: tb/tb_calc_display.sv
// tb_calc_display: scoreboard bench for calc_display.
// Expected frames are queued when stimulus is driven and checked against a
// full display refresh when frame_done (or err) shows up.
module tb_calc_display;

    localparam int unsigned SD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] status = 2'b10;
    logic [3:0] data = 4'd0;
    logic [3:0] pos = 4'd0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       frame_done;
    logic       err;

    calc_display #(.SCAN_DIV(SD), .NDIG(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .status     (status),
        .data       (data),
        .pos        (pos),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0][6:0] segs;
        logic            e;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] sh [8];
    int         n_vec = 0;
    int         n_bad = 0;

    localparam logic [6:0] TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        if (d < 4'd10) return TBL[d];
        return 7'h7F;
    endfunction

    // Expected display: digits above the most significant nonzero BCD digit blank.
    function automatic exp_t model_frame();
        exp_t w;
        int   msd;
        msd = 0;
        for (int i = 0; i < 8; i++)
            if (sh[i] != 4'd0 && sh[i] < 4'd10) msd = i;
        for (int i = 0; i < 8; i++)
            w.segs[i] = (i > msd) ? 7'h7F : ref_dec(sh[i]);
        w.e = 1'b0;
        return w;
    endfunction

    function automatic exp_t err_frame();
        exp_t w;
        w.segs = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h23};
        w.e    = 1'b1;
        return w;
    endfunction

    task automatic drive(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
        status = st;
        data   = d;
        pos    = p;
        @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0][3:0] vals, input int n);
        for (int i = 0; i < n; i++) begin
            drive(2'b01, vals[i], 4'(i));
            sh[i] = vals[i];
        end
        exp_q.push_back(model_frame());
        drive(2'b01, 4'd0, 4'd8);
        status = 2'b10;
        pos    = 4'd0;
    endtask

    task automatic pop_exp(output exp_t w);
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
            w = err_frame();
        end else begin
            w = exp_q.pop_front();
        end
    endtask

    // Watch a full refresh and compare every digit.
    task automatic scan_check(input string tag, input exp_t w);
        logic [6:0] seen [8];
        int         k;
        for (int j = 0; j < 8; j++) seen[j] = 'x;
        @(negedge clock);
        @(negedge clock);
        for (int c = 0; c < int'(9 * SD); c++) begin
            k = -1;
            for (int j = 0; j < 8; j++)
                if (an == ~(8'(1) << j)) k = j;
            if (k >= 0) seen[k] = seg;
            @(negedge clock);
        end
        for (int j = 0; j < 8; j++)
            check($sformatf("%s_seg%0d", tag, j), 32'(seen[j]), 32'(w.segs[j]));
        check({tag, "_err"}, 32'(err), 32'(w.e));
    endtask

    task automatic wait_commit(input string tag);
        exp_t w;
        for (int k = 0; k < 8 && !frame_done; k++) @(negedge clock);
        check({tag, "_done"}, 32'(frame_done), 32'd1);
        @(negedge clock);
        check({tag, "_pulse"}, 32'(frame_done), 32'd0);
        pop_exp(w);
        scan_check(tag, w);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_an"}, 32'(an), 32'hFE);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_fd"}, 32'(frame_done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        @(negedge clock);
        @(negedge clock);
        status = 2'b10;
        pos    = 4'd0;
        data   = 4'd0;
        reset  = 1'b1;
        for (int i = 0; i < 8; i++) sh[i] = 4'hF;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev;
        int         run;
        int         ntrans;
        int         pulses;
        exp_t       w;

        @(negedge clock);
        do_reset("rst");

        // 1: idle scan, blank display.
        prev   = an;
        run    = 0;
        ntrans = 0;
        for (int c = 0; c < 48; c++) begin
            @(negedge clock);
            run++;
            if (seg !== 7'h7F) check("t1_seg", 32'(seg), 32'h7F);
            if (frame_done !== 1'b0) check("t1_fd", 32'(frame_done), 32'd0);
            if (an !== prev) begin
                if (ntrans > 0) check("t1_run", 32'(run), 32'(SD));
                check("t1_seq", 32'(an), 32'({prev[6:0], prev[7]}));
                ntrans++;
                run  = 0;
                prev = an;
            end
        end
        check("t1_moving", 32'(ntrans >= 10), 32'd1);

        // 2: value 123, with an out-of-range pos that must be ignored.
        drive(2'b01, 4'd9, 4'd12);
        send_frame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3}, 8);
        wait_commit("t2");

        // 3: all zeros; a ready-status write must be ignored.
        drive(2'b10, 4'd9, 4'd5);
        send_frame('0, 8);
        wait_commit("t3");

        // 4: pos held at 8 gives a single commit; a later frame commits again.
        drive(2'b01, 4'd7, 4'd0);
        sh[0] = 4'd7;
        exp_q.push_back(model_frame());
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            status = 2'b01;
            pos    = 4'd8;
            @(negedge clock);
            if (frame_done) pulses++;
        end
        status = 2'b10;
        pos    = 4'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (frame_done) pulses++;
        end
        check("t4_pulses", 32'(pulses), 32'd1);
        pop_exp(w);
        scan_check("t4a", w);
        send_frame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6}, 1);
        wait_commit("t4b");

        // 5: error mid-frame is sticky and blocks later frames.
        drive(2'b01, 4'd1, 4'd0);
        drive(2'b00, 4'd2, 4'd1);
        check("t5_err_rise", 32'(err), 32'd1);
        status = 2'b10;
        exp_q.push_back(err_frame());
        pop_exp(w);
        scan_check("t5a", w);
        for (int i = 0; i < 8; i++) drive(2'b01, 4'd4, 4'(i));
        drive(2'b01, 4'd0, 4'd8);
        status = 2'b10;
        pos    = 4'd0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (frame_done) pulses++;
            @(negedge clock);
        end
        check("t5_no_commit", 32'(pulses), 32'd0);
        exp_q.push_back(err_frame());
        pop_exp(w);
        scan_check("t5b", w);

        // 6: reset during a frame discards the partial shadow contents.
        for (int i = 0; i < 4; i++) drive(2'b01, 4'd9, 4'(i));
        status = 2'b01;
        data   = 4'd9;
        pos    = 4'd4;
        do_reset("t6_rst");
        send_frame({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5}, 1);
        wait_commit("t6");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
